// File: rtl/breakout_pkg.sv
// Shared constants and helpers for the breakout input conditioner and serializer wrapper.
package breakout_pkg;

    localparam int N_BUTTON   = 8;
    localparam int N_PORT     = 8;
    localparam int N_LINK_POW = 4;

    typedef enum logic [0:0] {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

    // Ceiling log2; a value of 1 or less yields 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/breakout_debounce_bit.sv
// One conditioned input channel: synchronizer chain, optional debounce FSM and stable register.
module breakout_debounce_bit
    import breakout_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit DEBOUNCE_EN     = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_stable,
    output logic o_stable_next
);

    localparam int CNT_W_RAW = clog2(DEBOUNCE_CYCLES);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    db_state_t              r_state;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_synced;
    logic                   w_pre_synced;
    logic                   w_stable_nxt;
    db_state_t              w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    assign w_synced     = r_sync[SYNC_STAGES-1];
    assign w_pre_synced = r_sync[SYNC_STAGES-2];

    // Synchronizer chain, stable register, debounce state and counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_state  <= DB_STABLE;
            r_cnt    <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_stable <= w_stable_nxt;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Next-state logic. Without debounce the stable register itself is the
    // final synchronizer stage, so the output lands on edge SYNC_STAGES.
    always_comb begin
        w_stable_nxt = r_stable;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        if (!DEBOUNCE_EN) begin
            w_stable_nxt = w_pre_synced;
            w_state_nxt  = DB_STABLE;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                DB_STABLE: begin
                    if (w_synced == r_stable) begin
                        w_cnt_nxt = '0;
                    end else if (DEBOUNCE_CYCLES == 1) begin
                        w_stable_nxt = w_synced;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = DB_PENDING;
                    end
                end
                DB_PENDING: begin
                    if (w_synced == r_stable) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = DB_STABLE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_stable_nxt = w_synced;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = DB_STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DB_STABLE;
                end
            endcase
        end
    end

    assign o_stable      = r_stable;
    assign o_stable_next = w_stable_nxt;

endmodule

// File: rtl/breakout_input_conditioner.sv
// Synchronizes and debounces the breakout pins, and derives press pulses and a change strobe.
module breakout_input_conditioner
    import breakout_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1,
    parameter bit PORT_DEBOUNCE     = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_BUTTON-1:0]   i_button_raw,
    input  logic [N_PORT-1:0]     i_port_raw,
    input  logic [N_LINK_POW-1:0] i_link_pow_raw,
    output logic [N_BUTTON-1:0]   o_button,
    output logic [N_PORT-1:0]     o_port,
    output logic [N_LINK_POW-1:0] o_link_pow,
    output logic [N_BUTTON-1:0]   o_button_press,
    output logic                  o_change
);

    logic [N_BUTTON-1:0]   w_btn_in;
    logic [N_BUTTON-1:0]   w_btn_cur;
    logic [N_BUTTON-1:0]   w_btn_nxt;
    logic [N_PORT-1:0]     w_port_cur;
    logic [N_PORT-1:0]     w_port_nxt;
    logic [N_LINK_POW-1:0] w_lp_cur;
    logic [N_LINK_POW-1:0] w_lp_nxt;

    logic [N_BUTTON-1:0]   r_press;
    logic                  r_change;

    assign w_btn_in = BUTTON_ACTIVE_LOW ? ~i_button_raw : i_button_raw;

    for (genvar gi = 0; gi < N_BUTTON; gi++) begin : g_button
        breakout_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DEBOUNCE_EN     (1'b1)
        ) u_ch (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_raw         (w_btn_in[gi]),
            .o_stable      (w_btn_cur[gi]),
            .o_stable_next (w_btn_nxt[gi])
        );
    end

    for (genvar gi = 0; gi < N_PORT; gi++) begin : g_port
        breakout_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DEBOUNCE_EN     (PORT_DEBOUNCE)
        ) u_ch (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_raw         (i_port_raw[gi]),
            .o_stable      (w_port_cur[gi]),
            .o_stable_next (w_port_nxt[gi])
        );
    end

    for (genvar gi = 0; gi < N_LINK_POW; gi++) begin : g_link_pow
        breakout_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DEBOUNCE_EN     (1'b0)
        ) u_ch (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_raw         (i_link_pow_raw[gi]),
            .o_stable      (w_lp_cur[gi]),
            .o_stable_next (w_lp_nxt[gi])
        );
    end

    // Pulses are computed from each channel's next value so they line up with the output edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_press  <= '0;
            r_change <= 1'b0;
        end else begin
            r_press  <= w_btn_nxt & ~w_btn_cur;
            r_change <= (|(w_btn_nxt ^ w_btn_cur)) |
                        (|(w_port_nxt ^ w_port_cur)) |
                        (|(w_lp_nxt ^ w_lp_cur));
        end
    end

    assign o_button       = w_btn_cur;
    assign o_port         = w_port_cur;
    assign o_link_pow     = w_lp_cur;
    assign o_button_press = r_press;
    assign o_change       = r_change;

endmodule

// File: tb/tb_breakout_input_conditioner.sv
// Directed bench: three conditioner variants checked every cycle against an edge-history model.
module tb_breakout_input_conditioner;

    localparam int SYNC_S = 2;
    localparam int NI     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn_raw  = 8'hFF;
    logic [7:0] port_raw = 8'hFF;
    logic [3:0] lp_raw   = 4'hF;

    logic [NI-1:0][7:0] d_btn;
    logic [NI-1:0][7:0] d_port;
    logic [NI-1:0][3:0] d_lp;
    logic [NI-1:0][7:0] d_press;
    logic [NI-1:0]      d_change;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // u0: D=4 ports sync-only; u1: D=1 ports debounced; u2: D=4 ports debounced
    breakout_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BUTTON_ACTIVE_LOW(1'b1), .PORT_DEBOUNCE(1'b0)) u0 (
        .i_clk(clk), .i_reset(rst), .i_button_raw(btn_raw), .i_port_raw(port_raw), .i_link_pow_raw(lp_raw),
        .o_button(d_btn[0]), .o_port(d_port[0]), .o_link_pow(d_lp[0]), .o_button_press(d_press[0]), .o_change(d_change[0]));
    breakout_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .BUTTON_ACTIVE_LOW(1'b1), .PORT_DEBOUNCE(1'b1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_button_raw(btn_raw), .i_port_raw(port_raw), .i_link_pow_raw(lp_raw),
        .o_button(d_btn[1]), .o_port(d_port[1]), .o_link_pow(d_lp[1]), .o_button_press(d_press[1]), .o_change(d_change[1]));
    breakout_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BUTTON_ACTIVE_LOW(1'b1), .PORT_DEBOUNCE(1'b1)) u2 (
        .i_clk(clk), .i_reset(rst), .i_button_raw(btn_raw), .i_port_raw(port_raw), .i_link_pow_raw(lp_raw),
        .o_button(d_btn[2]), .o_port(d_port[2]), .o_link_pow(d_lp[2]), .o_button_press(d_press[2]), .o_change(d_change[2]));

    function automatic int db_cycles(input int k);
        return (k == 1) ? 1 : 4;
    endfunction

    function automatic bit is_debounced(input int k, input int b);
        if (b < 8) return 1'b1;
        if (b < 16) return (k != 0);
        return 1'b0;
    endfunction

    // Model state: log of pressed-polarity raw samples per edge, last reset edge.
    logic [19:0] raw_log [0:4095];
    int          edge_n = 0;
    int          lr     = 0;
    bit          valid  = 1'b0;
    logic [19:0] m_out    [NI];
    logic [7:0]  m_press  [NI];
    logic        m_change [NI];

    // Level seen at the end of the synchronizer just before edge e.
    function automatic logic syncd(input int e, input int b);
        if (e - SYNC_S > lr) return raw_log[e - SYNC_S][b];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        logic [19:0] nxt;
        logic        v;
        bit          ok;
        int          d;
        edge_n = edge_n + 1;
        if (rst) begin
            lr    = edge_n;
            valid = 1'b1;
            for (int k = 0; k < NI; k++) begin
                m_out[k]    = '0;
                m_press[k]  = '0;
                m_change[k] = 1'b0;
            end
        end else if (valid) begin
            raw_log[edge_n] = {lp_raw, port_raw, ~btn_raw};
            for (int k = 0; k < NI; k++) begin
                nxt = m_out[k];
                d   = db_cycles(k);
                for (int b = 0; b < 20; b++) begin
                    if (is_debounced(k, b)) begin
                        // accept only after d consecutive identical synced levels since reset
                        v  = syncd(edge_n, b);
                        ok = (edge_n - d + 1 > lr);
                        for (int j = 0; j < d; j++) begin
                            if (syncd(edge_n - j, b) != v) ok = 1'b0;
                        end
                        if (ok && (v != m_out[k][b])) nxt[b] = v;
                    end else begin
                        nxt[b] = (edge_n - SYNC_S + 1 > lr) ? raw_log[edge_n - SYNC_S + 1][b] : 1'b0;
                    end
                end
                m_press[k]  = nxt[7:0] & ~m_out[k][7:0];
                m_change[k] = (nxt != m_out[k]);
                m_out[k]    = nxt;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("u%0d.o_button", k),       32'(d_btn[k]),    32'(m_out[k][7:0]));
                chk($sformatf("u%0d.o_port", k),         32'(d_port[k]),   32'(m_out[k][15:8]));
                chk($sformatf("u%0d.o_link_pow", k),     32'(d_lp[k]),     32'(m_out[k][19:16]));
                chk($sformatf("u%0d.o_button_press", k), 32'(d_press[k]), 32'(m_press[k]));
                chk($sformatf("u%0d.o_change", k),       32'(d_change[k]), 32'(m_change[k]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every raw pin high
        step(1);
        chk("rst_button", 32'(d_btn[0]), 32'h00);
        chk("rst_port", 32'(d_port[0]), 32'h00);
        step(2);
        chk("rst_link_pow", 32'(d_lp[0]), 32'h0);
        port_raw = 8'h00;
        lp_raw   = 4'h0;
        rst      = 1'b0;
        step(8);
        chk("post_rst_button", 32'(d_btn[0]), 32'h00);
        chk("post_rst_change", 32'(d_change[0]), 32'h0);

        // Clean press of button 0
        btn_raw = 8'hFE;
        step(5);
        chk("press_e5_button", 32'(d_btn[0]), 32'h00);
        step(1);
        chk("press_e6_button", 32'(d_btn[0]), 32'h01);
        chk("press_e6_pulse", 32'(d_press[0]), 32'h01);
        chk("press_e6_change", 32'(d_change[0]), 32'h1);
        step(1);
        chk("press_e7_pulse", 32'(d_press[0]), 32'h00);
        chk("press_e7_change", 32'(d_change[0]), 32'h0);
        step(6);

        // Three-cycle glitch on button 3
        btn_raw = 8'hF6;
        step(3);
        btn_raw = 8'hFE;
        step(8);
        chk("glitch_button", 32'(d_btn[0]), 32'h01);

        // Sync-only paths
        lp_raw   = 4'hA;
        port_raw = 8'h5A;
        step(1);
        chk("sync_e1_link_pow", 32'(d_lp[0]), 32'h0);
        step(1);
        chk("sync_e2_link_pow", 32'(d_lp[0]), 32'hA);
        chk("sync_e2_port", 32'(d_port[0]), 32'h5A);
        chk("sync_e2_change", 32'(d_change[0]), 32'h1);
        step(1);
        chk("sync_e3_change", 32'(d_change[0]), 32'h0);
        step(6);

        // Release, then press interrupted by reset on edge 4
        btn_raw = 8'hFF;
        step(5);
        chk("rel_e5_button", 32'(d_btn[0]), 32'h01);
        step(1);
        chk("rel_e6_button", 32'(d_btn[0]), 32'h00);
        chk("rel_e6_change", 32'(d_change[0]), 32'h1);
        chk("rel_e6_pulse", 32'(d_press[0]), 32'h00);
        step(6);
        btn_raw = 8'hFE;
        step(3);
        rst = 1'b1;
        step(1);
        chk("midrst_button", 32'(d_btn[0]), 32'h00);
        chk("midrst_pulse", 32'(d_press[0]), 32'h00);
        rst = 1'b0;
        step(5);
        chk("after_rst_e5_button", 32'(d_btn[0]), 32'h00);
        step(1);
        chk("after_rst_e6_button", 32'(d_btn[0]), 32'h01);
        chk("after_rst_e6_pulse", 32'(d_press[0]), 32'h01);
        step(10);

        // Single-cycle debounce and debounced ports
        btn_raw = 8'hFC;
        step(2);
        chk("d1_e2_button", 32'(d_btn[1]), 32'h01);
        step(1);
        chk("d1_e3_button", 32'(d_btn[1]), 32'h03);
        chk("d1_e3_pulse", 32'(d_press[1]), 32'h02);
        step(8);
        port_raw = 8'h5B;
        step(1);
        port_raw = 8'h5A;
        step(2);
        chk("d1_port_toggle", 32'(d_port[1]), 32'h5B);
        chk("d4_port_toggle", 32'(d_port[2]), 32'h5A);
        step(1);
        chk("d1_port_back", 32'(d_port[1]), 32'h5A);
        step(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/breakout_input_conditioner.md
Name: breakout_input_conditioner

Overview:
- Front-end stage feeding the breakout serializer.
- Takes raw asynchronous pin levels (8 buttons, 8 digital inputs, 4 link-power indicators) and synchronizes them into the frame clock domain. Debounces the buttons, and optionally the digital inputs.
- Presents clean, registered parallel words: o_button, o_port, o_link_pow connect directly to the serializer's i_button, i_port, i_link_pow.
- Also emits per-button press pulses and an any-change strobe for local status logic.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth per input bit; legal range is 2 or more.
- DEBOUNCE_CYCLES, 50000, consecutive i_clk cycles a changed level must persist before acceptance; legal range is 1 or more.
- BUTTON_ACTIVE_LOW, 1, when 1 raw buttons are inverted before synchronization, so that pressed = 1.
- PORT_DEBOUNCE, 0, when 1 port bits use the same debounce as buttons; when 0 port bits are synchronized only.

Ports:
- i_clk  input  1  frame clock (same clock as the serializer's i_clk).
- i_reset  input  1  synchronous, active-high reset.
- i_button_raw  input  8  raw button pins, asynchronous.
- i_port_raw  input  8  raw digital-input pins, asynchronous.
- i_link_pow_raw  input  4  raw link-power indicators, asynchronous.
- o_button  output  8  debounced buttons, pressed = 1.
- o_port  output  8  conditioned digital inputs.
- o_link_pow  output  4  synchronized link-power bits.
- o_button_press  output  8  one-cycle pulse per bit on each accepted 0->1 transition of o_button.
- o_change  output  1  one-cycle pulse on any cycle in which any bit of o_button, o_port or o_link_pow changes.

Behaviour:
- Clock and reset:
  - Single clock domain; every flop is updated on posedge i_clk.
  - Reset is synchronous and active-high; it is sampled on posedge i_clk and overrides all other logic.
  - Reset values: all sync flops, debounce counters and stable registers are 0; all outputs are 0.
  - Reset mid-debounce discards the pending count; there is no output pulse on reset entry or exit.
- Polarity: the button inversion (BUTTON_ACTIVE_LOW) is applied before the first sync flop. Ports and link-power bits are never inverted.
- Synchronizer: a SYNC_STAGES-deep flop chain per bit. Its last stage is the "synced" value.
- Debounce: one independent channel per bit, built as a two-state machine with a counter of width clog2(DEBOUNCE_CYCLES) bits (minimum 1 bit).
  - STABLE: count = 0. If synced == stable, remain in STABLE. If synced != stable, count <= 1 and go to PENDING. With DEBOUNCE_CYCLES = 1, stable <= synced immediately and stay in STABLE.
  - PENDING: if synced == stable (a glitch ended), count <= 0 and return to STABLE. This suppresses the output change entirely.
  - PENDING: if synced != stable and count == DEBOUNCE_CYCLES-1, stable <= synced, count <= 0, return to STABLE.
  - PENDING: otherwise count increments by 1.
  - The counter never wraps: the compare fires before wrap-around.
- Latency:
  - Count edges so that edge 1 is the first posedge at which a new raw level is sampled, with the raw level held constant from then on.
  - Debounced bits: the output updates on edge SYNC_STAGES + DEBOUNCE_CYCLES.
  - Sync-only bits (link-power, and ports when PORT_DEBOUNCE = 0): the output updates on edge SYNC_STAGES.
- Glitch rejection: any synced excursion shorter than DEBOUNCE_CYCLES cycles produces no output change.
- Output registers:
  - o_button, o_port and o_link_pow are the stable registers themselves; there is no combinational path from inputs to outputs.
  - o_button_press[i] and o_change are registered. They assert on the same edge that the corresponding output bit changes and deassert on the next edge.
  - Simultaneous changes on several bits in one cycle produce a single one-cycle o_change. Back-to-back accepted changes in consecutive cycles keep o_change high for each of those cycles.
- 1->0 button transitions update o_button and o_change, but never o_button_press.

Decomposition:
- Shared package breakout_pkg holds:
  - N_BUTTON = 8, N_PORT = 8, N_LINK_POW = 4 (also consumed by the serializer wrapper);
  - a clog2 function;
  - a DB_STABLE/DB_PENDING state encoding.
- Natural sub-module: breakout_debounce_bit, holding one channel's synchronizer, counter, state and stable register, parameterized by SYNC_STAGES, DEBOUNCE_CYCLES and a DEBOUNCE_EN bit. The top level instantiates 20 of them (generate loops) and adds the press-pulse and change logic.

Test Plan (SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, BUTTON_ACTIVE_LOW = 1, PORT_DEBOUNCE = 0 unless noted):
1. Reset: hold i_reset for 3 cycles with all raw inputs at 1 -> all outputs 0 during reset. After release, o_button stays 8'h00 and no o_button_press or o_change pulse appears.
2. Clean press: i_button_raw 8'hFF->8'hFE, held -> o_button = 8'h01 on edge 6. o_button_press = 8'h01 and o_change = 1 on edge 6 only.
3. Glitch rejection: i_button_raw[3] low for exactly 3 synced cycles, then high -> o_button, o_button_press and o_change never change.
4. Sync-only paths: i_link_pow_raw 4'h0->4'hA together with i_port_raw 8'h00->8'h5A on the same edge -> o_link_pow = 4'hA and o_port = 8'h5A on edge 2, with a single one-cycle o_change.
5. Release and reset mid-count: a release (raw 1) yields o_button 0 on edge 6 with o_change = 1 and no press pulse. A second press with i_reset asserted on edge 4 (count = 2) -> outputs 0, no pulse; after reset deasserts, the press is accepted 6 edges later.
6. DEBOUNCE_CYCLES = 1 and PORT_DEBOUNCE = 1: a press yields o_button update on edge 3. A port bit toggled for 1 cycle is suppressed with DEBOUNCE_CYCLES = 4 and passes with DEBOUNCE_CYCLES = 1.
